// File: rtl/issue_queue_mw_pkg.sv
// Shared types for the multi-write issue queue: element layout, bool helpers
// and a saturating adder for the optional performance counters.
package issue_queue_mw_pkg;

  typedef logic bool;
  localparam bool TRUE  = 1'b1;
  localparam bool FALSE = 1'b0;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] dest;
    logic [4:0] src;
  } ISSUE_QUEUE_ELEMENT;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/iq_window_read.sv
// Combinational head window: rotates POP_W entries out of storage starting at
// head and flags each lane valid when it lies inside the occupied region.
module iq_window_read
  import issue_queue_mw_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int POP_W  = 2,
  parameter int ELEM_W = $bits(ISSUE_QUEUE_ELEMENT)
) (
  input  logic [DEPTH*ELEM_W-1:0]     mem_flat,
  input  logic [$clog2(DEPTH)-1:0]    head,
  input  logic [$clog2(DEPTH+1)-1:0]  count,
  output logic [POP_W*ELEM_W-1:0]     out_data,
  output logic [POP_W-1:0]            out_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  for (genvar i = 0; i < POP_W; i++) begin : g_lane
    logic [PTR_W-1:0] idx;
    // Pointer overflow gives the circular wrap for free.
    assign idx = head + PTR_W'(i);
    assign out_data[i*ELEM_W +: ELEM_W] = mem_flat[int'(idx)*ELEM_W +: ELEM_W];
    assign out_valid[i] = (CNT_W'(i) < count) ? TRUE : FALSE;
  end

endmodule

// File: rtl/issue_queue_mw.sv
// Parametrised circular issue queue: up to PUSH_W pushes and POP_W pops per cycle.
// Define IQ_PERF_CNT_EN to add saturating full/pop/clipped-push counters.
module issue_queue_mw
  import issue_queue_mw_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PUSH_W = 4,
  parameter int POP_W  = 2,
  parameter int ELEM_W = $bits(ISSUE_QUEUE_ELEMENT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flash,
  input  logic [PUSH_W*ELEM_W-1:0]       in_data,
  input  logic [$clog2(PUSH_W+1)-1:0]    in_data_number,
  output logic [$clog2(DEPTH+1)-1:0]     iq_size_left,
  output logic [$clog2(DEPTH+1)-1:0]     iq_count,
  output logic [$clog2(POP_W+1)-1:0]     iq_size,
  output logic [POP_W*ELEM_W-1:0]        out_data,
  output logic [POP_W-1:0]               out_valid,
  input  logic [$clog2(POP_W+1)-1:0]     out_data_number
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_full_cycles,
  output logic [31:0]                    perf_pop_total,
  output logic [31:0]                    perf_push_clipped
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int OUT_W = $clog2(POP_W+1);

  logic [ELEM_W-1:0]       mem [DEPTH];
  logic [DEPTH*ELEM_W-1:0] mem_flat;
  logic [PTR_W-1:0]        head, tail;
  logic [CNT_W-1:0]        count, free_slots, push_req, pop_req, push_acc, pop_acc;

  // Both clips use the pre-update count, so pops never make room for this cycle's pushes.
  assign free_slots = CNT_W'(DEPTH) - count;
  assign push_req   = CNT_W'(in_data_number);
  assign pop_req    = CNT_W'(out_data_number);
  assign push_acc   = (push_req < free_slots) ? push_req : free_slots;
  assign pop_acc    = (pop_req < count) ? pop_req : count;

  assign iq_count     = count;
  assign iq_size_left = free_slots;
  assign iq_size      = (count < CNT_W'(POP_W)) ? OUT_W'(count) : OUT_W'(POP_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_acc);
      tail  <= tail + PTR_W'(push_acc);
      count <= count + push_acc - pop_acc;
    end
  end

  // Storage is deliberately left unreset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (!flash) begin
      for (int k = 0; k < PUSH_W; k++) begin
        if (CNT_W'(k) < push_acc) begin
          mem[tail + PTR_W'(k)] <= in_data[k*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*ELEM_W +: ELEM_W] = mem[g];
  end

  iq_window_read #(
    .DEPTH  (DEPTH),
    .POP_W  (POP_W),
    .ELEM_W (ELEM_W)
  ) u_window (
    .mem_flat  (mem_flat),
    .head      (head),
    .count     (count),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

`ifdef IQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_full_cycles  <= '0;
      perf_pop_total    <= '0;
      perf_push_clipped <= '0;
    end else if (flash) begin
      perf_full_cycles  <= '0;
      perf_pop_total    <= '0;
      perf_push_clipped <= '0;
    end else begin
      perf_full_cycles  <= sat_add32(perf_full_cycles, {31'd0, count == CNT_W'(DEPTH)});
      perf_pop_total    <= sat_add32(perf_pop_total, 32'(pop_acc));
      perf_push_clipped <= sat_add32(perf_push_clipped, 32'(push_req - push_acc));
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue_mw.sv
// Self-checking bench for issue_queue_mw: directed vector table, wrap/reset
// sequences and a randomized run against a queue-based reference model.
module tb_issue_queue_mw;
  import issue_queue_mw_pkg::*;

  localparam int DEPTH  = 8;
  localparam int PUSH_W = 4;
  localparam int POP_W  = 2;
  localparam int ELEM_W = $bits(ISSUE_QUEUE_ELEMENT);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flash;
  logic [PUSH_W*ELEM_W-1:0] in_data;
  logic [2:0]               in_data_number;
  logic [3:0]               iq_size_left;
  logic [3:0]               iq_count;
  logic [1:0]               iq_size;
  logic [POP_W*ELEM_W-1:0]  out_data;
  logic [POP_W-1:0]         out_valid;
  logic [1:0]               out_data_number;
`ifdef IQ_PERF_CNT_EN
  logic [31:0] perf_full_cycles, perf_pop_total, perf_push_clipped;
  int          m_full, m_pops, m_clipped;
`endif

  issue_queue_mw #(
    .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .ELEM_W(ELEM_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flash           (flash),
    .in_data         (in_data),
    .in_data_number  (in_data_number),
    .iq_size_left    (iq_size_left),
    .iq_count        (iq_count),
    .iq_size         (iq_size),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_data_number (out_data_number)
`ifdef IQ_PERF_CNT_EN
    ,
    .perf_full_cycles  (perf_full_cycles),
    .perf_pop_total    (perf_pop_total),
    .perf_push_clipped (perf_push_clipped)
`endif
  );

  always #5 clk = ~clk;

  logic [ELEM_W-1:0] model_q[$];
  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int         n_push;
    int         n_pop;
    bit         fl;
    int         exp_count;
    int         exp_left;
    logic [1:0] exp_valid;
  } vec_t;

  vec_t vecs[12];

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference model: a plain queue; pops come from the front, pushes clip to free space.
  task automatic model_step(input int n_push, input int n_pop, input bit fl,
                            input logic [PUSH_W*ELEM_W-1:0] data);
    int sz, pop_acc, push_acc;
    sz = model_q.size();
    if (fl) begin
      model_q.delete();
`ifdef IQ_PERF_CNT_EN
      m_full = 0; m_pops = 0; m_clipped = 0;
`endif
    end else begin
      pop_acc  = (n_pop < sz) ? n_pop : sz;
      push_acc = (n_push < DEPTH - sz) ? n_push : DEPTH - sz;
`ifdef IQ_PERF_CNT_EN
      if (sz == DEPTH) m_full++;
      m_pops    += pop_acc;
      m_clipped += n_push - push_acc;
`endif
      repeat (pop_acc) void'(model_q.pop_front());
      for (int k = 0; k < push_acc; k++) model_q.push_back(data[k*ELEM_W +: ELEM_W]);
    end
  endtask

  task automatic apply_stimulus(input int n_push, input int n_pop, input bit fl,
                                input logic [PUSH_W*ELEM_W-1:0] data);
    in_data         = data;
    in_data_number  = 3'(n_push);
    out_data_number = 2'(n_pop);
    flash           = fl;
    @(posedge clk);
    model_step(n_push, n_pop, fl, data);
    #1;
  endtask

  task automatic check_output();
    int sz;
    logic [POP_W-1:0] exp_valid;
    sz = model_q.size();
    compare("iq_count", 32'(iq_count), 32'(sz));
    compare("iq_size_left", 32'(iq_size_left), 32'(DEPTH - sz));
    compare("iq_size", 32'(iq_size), 32'((sz < POP_W) ? sz : POP_W));
    for (int i = 0; i < POP_W; i++) exp_valid[i] = (i < sz);
    compare("out_valid", 32'(out_valid), 32'(exp_valid));
    for (int i = 0; i < POP_W; i++)
      if (i < sz) compare("out_data_lane", 32'(out_data[i*ELEM_W +: ELEM_W]), 32'(model_q[i]));
`ifdef IQ_PERF_CNT_EN
    compare("perf_full_cycles", perf_full_cycles, 32'(m_full));
    compare("perf_pop_total", perf_pop_total, 32'(m_pops));
    compare("perf_push_clipped", perf_push_clipped, 32'(m_clipped));
`endif
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [PUSH_W*ELEM_W-1:0] data;

    vecs[0]  = '{4, 0, 1'b0, 4, 4, 2'b11};
    vecs[1]  = '{4, 2, 1'b0, 6, 2, 2'b11};
    vecs[2]  = '{4, 0, 1'b0, 8, 0, 2'b11};
    vecs[3]  = '{4, 2, 1'b0, 6, 2, 2'b11};
    vecs[4]  = '{0, 2, 1'b0, 4, 4, 2'b11};
    vecs[5]  = '{0, 2, 1'b0, 2, 6, 2'b11};
    vecs[6]  = '{0, 2, 1'b0, 0, 8, 2'b00};
    vecs[7]  = '{1, 2, 1'b0, 1, 7, 2'b01};
    vecs[8]  = '{0, 2, 1'b0, 0, 8, 2'b00};
    vecs[9]  = '{3, 0, 1'b0, 3, 5, 2'b11};
    vecs[10] = '{2, 0, 1'b0, 5, 3, 2'b11};
    vecs[11] = '{3, 2, 1'b1, 0, 8, 2'b00};

    rst = 1'b1; flash = 1'b0; in_data = '0; in_data_number = '0; out_data_number = '0;
`ifdef IQ_PERF_CNT_EN
    m_full = 0; m_pops = 0; m_clipped = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    compare("reset_count", 32'(iq_count), 32'd0);
    compare("reset_left", 32'(iq_size_left), 32'd8);
    compare("reset_valid", 32'(out_valid), 32'd0);
    compare("reset_size", 32'(iq_size), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      data = {$urandom, $urandom};
      apply_stimulus(vecs[v].n_push, vecs[v].n_pop, vecs[v].fl, data);
      compare("tbl_count", 32'(iq_count), 32'(vecs[v].exp_count));
      compare("tbl_left", 32'(iq_size_left), 32'(vecs[v].exp_left));
      compare("tbl_valid", 32'(out_valid), 32'(vecs[v].exp_valid));
      check_output();
    end

    // Walk head and tail to entry 6 with an empty queue, then push across the wrap.
    apply_stimulus(4, 0, 1'b0, {$urandom, $urandom}); check_output();
    apply_stimulus(2, 0, 1'b0, {$urandom, $urandom}); check_output();
    repeat (3) begin
      apply_stimulus(0, 2, 1'b0, {$urandom, $urandom}); check_output();
    end
    apply_stimulus(4, 0, 1'b0, {16'hA003, 16'hA002, 16'hA001, 16'hA000});
    check_output();
    compare("wrap_lane0", 32'(out_data[15:0]), 32'hA000);
    compare("wrap_lane1", 32'(out_data[31:16]), 32'hA001);
    apply_stimulus(0, 2, 1'b0, {$urandom, $urandom});
    check_output();
    compare("wrap_lane0_b", 32'(out_data[15:0]), 32'hA002);
    compare("wrap_lane1_b", 32'(out_data[31:16]), 32'hA003);
    apply_stimulus(0, 2, 1'b0, {$urandom, $urandom});
    check_output();
    apply_stimulus(1, 0, 1'b0, {$urandom, $urandom, 16'hB000});
    check_output();
    compare("wrap_head_tail", 32'(out_data[15:0]), 32'hB000);

    // Asynchronous reset in the middle of filling.
    apply_stimulus(3, 0, 1'b0, {$urandom, $urandom}); check_output();
    apply_stimulus(3, 1, 1'b0, {$urandom, $urandom}); check_output();
    in_data_number = '0; out_data_number = '0;
    #2;
    rst = 1'b1;
    #1;
    compare("async_rst_count", 32'(iq_count), 32'd0);
    compare("async_rst_left", 32'(iq_size_left), 32'd8);
    compare("async_rst_valid", 32'(out_valid), 32'd0);
    compare("async_rst_size", 32'(iq_size), 32'd0);
    model_q.delete();
`ifdef IQ_PERF_CNT_EN
    m_full = 0; m_pops = 0; m_clipped = 0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output();

    for (int c = 0; c < 400; c++) begin
      apply_stimulus($urandom_range(0, PUSH_W), $urandom_range(0, POP_W),
                     ($urandom_range(0, 31) == 0), {$urandom, $urandom});
      check_output();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
